// File: rtl/lfsr_timer_sched.sv
// lfsr_timer_sched: round-robin sharing of one 4-bit LFSR expiry timer among NUM_REQ requesters.
// Define LFSR_SCHED_ABORT_EN to let an owner abort by dropping req during LOAD or RUN.
module lfsr_timer_sched #(
  parameter int NUM_REQ = 4,
  parameter int ID_W = $clog2(NUM_REQ)
) (
  input  logic                 clk,
  input  logic                 resetb,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [4*NUM_REQ-1:0] seed,
  output logic [NUM_REQ-1:0]   gnt,
  output logic [NUM_REQ-1:0]   done,
  output logic                 busy,
  output logic [ID_W-1:0]      active_id
);
  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;
  state_t state;
  logic [ID_W-1:0] ptr, pick, nxt_ptr;
  logic [3:0] lfsr, lfsr_step, seed_sel;
  logic found, abort;
  int j;
  assign lfsr_step = {lfsr[0], lfsr[3] ^ lfsr[0], lfsr[2], lfsr[1]};
  assign seed_sel = seed[4*active_id +: 4];
  assign nxt_ptr = (active_id == ID_W'(NUM_REQ-1)) ? '0 : active_id + 1'b1;
  assign busy = state != IDLE;
  assign gnt = busy ? NUM_REQ'(1) << active_id : '0;
  assign done = (state == DONE) ? NUM_REQ'(1) << active_id : '0;
`ifdef LFSR_SCHED_ABORT_EN
  assign abort = !req[active_id];
`else
  assign abort = 1'b0;
`endif
  // first requester at or after the pointer, wrapping around
  always_comb begin
    pick = '0;
    found = 1'b0;
    j = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      j = (int'(ptr) + i) % NUM_REQ;
      if (!found && req[ID_W'(j)]) begin
        found = 1'b1;
        pick = ID_W'(j);
      end
    end
  end
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      state <= IDLE;
      ptr <= '0;
      active_id <= '0;
      lfsr <= 4'b1111;
    end else begin
      case (state)
        IDLE: if (found) begin
          active_id <= pick;
          state <= LOAD;
        end
        LOAD: if (abort) begin
          ptr <= nxt_ptr;
          state <= IDLE;
        end else begin
          lfsr <= (seed_sel == 4'b0000) ? 4'b1111 : seed_sel;
          state <= RUN;
        end
        RUN: if (abort) begin
          ptr <= nxt_ptr;
          state <= IDLE;
        end else if (lfsr == 4'b0111) state <= DONE;
        else lfsr <= lfsr_step;
        default: begin
          ptr <= nxt_ptr;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule
